// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - request/status handshake between a PS/2 transmit client and ps2_host_tx
interface ps2_host_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (output tx_start, output tx_data, input tx_busy, input tx_done, input tx_error);
    modport slave  (input tx_start, input tx_data, output tx_busy, output tx_done, output tx_error);
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter over open-drain clock/data
// Optional ack-level checking is enabled by defining PS2TX_ACK_CHECK_EN.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1820,
    parameter int TIMEOUT_CYCLES = 280000,
    parameter int CNT_W          = 19
) (
    input  logic         clk,
    input  logic         rst_n,
    ps2_host_tx_if.slave tx,
    input  logic         ps2clk_in,
    input  logic         ps2data_in,
    output logic         ps2clk_oe,
    output logic         ps2data_oe
);
    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE, DONE, ERR
    } state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic [10:0]       shift;
    logic [3:0]        bitcnt;
    logic              data_drv;
    logic              clk_m, clk_s, clk_p, data_m, data_s;
    logic              fall, cnt_inh_end, cnt_tmo_end, timeout;
`ifdef PS2TX_ACK_CHECK_EN
    logic              ack_bad;
`endif

    assign fall        = clk_p & ~clk_s;
    assign cnt_inh_end = (cnt == CNT_W'(INHIBIT_CYCLES - 1));
    assign cnt_tmo_end = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout     = cnt_tmo_end &&
                         (state == REQ || state == BITS || state == ACK || state == WAIT_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            shift    <= '0;
            bitcnt   <= '0;
            data_drv <= 1'b0;
            // Synchronizers reset to the idle bus level so no edge is fabricated
            clk_m    <= 1'b1;
            clk_s    <= 1'b1;
            clk_p    <= 1'b1;
            data_m   <= 1'b1;
            data_s   <= 1'b1;
`ifdef PS2TX_ACK_CHECK_EN
            ack_bad  <= 1'b0;
`endif
        end else begin
            state  <= next_state;
            clk_m  <= ps2clk_in;
            clk_s  <= clk_m;
            clk_p  <= clk_s;
            data_m <= ps2data_in;
            data_s <= data_m;

            if (state == IDLE || (state == INHIBIT && cnt_inh_end))
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);

            // Bit 0 holds the start bit so the first device edge keeps it on the wire
            if (state == IDLE && tx.tx_start)
                shift <= {1'b1, ~^tx.tx_data, tx.tx_data, 1'b0};
            else if (state == BITS && fall)
                shift <= {1'b0, shift[10:1]};

            if (state == IDLE)
                bitcnt <= '0;
            else if (state == BITS && fall)
                bitcnt <= bitcnt + 4'd1;

            if (state == REQ)
                data_drv <= 1'b1;
            else if (state == BITS && fall)
                data_drv <= ~shift[0];

`ifdef PS2TX_ACK_CHECK_EN
            if (state == ACK && fall)
                ack_bad <= data_s;
`endif
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (tx.tx_start) next_state = INHIBIT;
            INHIBIT:   if (cnt_inh_end) next_state = REQ;
            REQ:       next_state = BITS;
            BITS:      if (fall && bitcnt == 4'd10) next_state = ACK;
            ACK:       if (fall) next_state = WAIT_IDLE;
            WAIT_IDLE: if (clk_s && data_s) begin
`ifdef PS2TX_ACK_CHECK_EN
                next_state = ack_bad ? ERR : DONE;
`else
                next_state = DONE;
`endif
            end
            DONE:      next_state = IDLE;
            ERR:       next_state = IDLE;
            default:   next_state = IDLE;
        endcase
        // Timeout overrides any same-cycle completion
        if (timeout)
            next_state = ERR;
    end

    always_comb begin
        tx.tx_busy  = (state == INHIBIT) || (state == REQ) || (state == BITS) ||
                      (state == ACK) || (state == WAIT_IDLE);
        tx.tx_done  = (state == DONE);
        tx.tx_error = (state == ERR);
        ps2clk_oe   = (state == INHIBIT) || (state == REQ);
        ps2data_oe  = (state == REQ) || (state == BITS && data_drv);
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with an open-drain PS/2 device model
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TMO = 1000;
    localparam int H   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2clk_in, ps2data_in, ps2clk_oe, ps2data_oe;

    ps2_host_tx_if bus ();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CNT_W(19)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx         (bus),
        .ps2clk_in  (ps2clk_in),
        .ps2data_in (ps2data_in),
        .ps2clk_oe  (ps2clk_oe),
        .ps2data_oe (ps2data_oe)
    );

    assign ps2clk_in  = dev_clk & ~ps2clk_oe;
    assign ps2data_in = dev_data & ~ps2data_oe;

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0;
    int t_clk_rise = 0, t_data_rise = 0, t_clk_fall = 0, t_err = 0;
    logic busy_at_done = 1'b0;
    logic [1:0] oe_at_err = 2'b00;
    logic prev_clk_oe = 1'b0, prev_data_oe = 1'b0;

    always @(negedge clk) begin
        cyc          <= cyc + 1;
        prev_clk_oe  <= ps2clk_oe;
        prev_data_oe <= ps2data_oe;
        if (ps2clk_oe && !prev_clk_oe) t_clk_rise <= cyc;
        if (!ps2clk_oe && prev_clk_oe) t_clk_fall <= cyc;
        if (ps2data_oe && !prev_data_oe && ps2clk_oe) t_data_rise <= cyc;
        if (bus.tx_done) begin
            done_cnt     <= done_cnt + 1;
            busy_at_done <= bus.tx_busy;
        end
        if (bus.tx_error) begin
            err_cnt   <= err_cnt + 1;
            t_err     <= cyc;
            oe_at_err <= {ps2clk_oe, ps2data_oe};
        end
    end

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
    endtask

    // Device side: waits for the request, then clocks n_fall falling edges, sampling on each rise
    task automatic dev_frame(input int n_fall, input logic ack_low,
                             output logic [10:0] cap, output logic ok);
        int w;
        cap = '0;
        ok  = 1'b1;
        w   = 0;
        while (ps2clk_oe !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        while (ps2clk_oe !== 1'b0 && w < 400) begin @(negedge clk); w++; end
        if (w >= 400) begin ok = 1'b0; return; end
        repeat (4) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            if (k == n_fall) return;
            cap[k-1] = ps2data_in;
            dev_clk  = 1'b1;
            repeat (H) @(negedge clk);
        end
        dev_data = ack_low ? 1'b0 : 1'b1;
        repeat (H) @(negedge clk);
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic wait_end(input int d0, input int e0, output logic ok);
        int w;
        w = 0;
        while (done_cnt == d0 && err_cnt == e0 && w < 2 * TMO) begin @(negedge clk); w++; end
        ok = (w < 2 * TMO);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (bus.tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.tx_busy); end
        vectors++; if (bus.tx_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.tx_done); end
        vectors++; if (bus.tx_error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b expected 0", bus.tx_error); end
        vectors++; if (ps2clk_oe !== 1'b0) begin miscompares++; $display("FAIL reset_clk_oe: got %b expected 0", ps2clk_oe); end
        vectors++; if (ps2data_oe !== 1'b0) begin miscompares++; $display("FAIL reset_data_oe: got %b expected 0", ps2data_oe); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_frame_ed;
        int d0, e0;
        logic [10:0] cap;
        logic ok;
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hED);
        vectors++; if (bus.tx_busy !== 1'b1) begin miscompares++; $display("FAIL ed_busy_start: got %b expected 1", bus.tx_busy); end
        dev_frame(12, 1'b1, cap, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL ed_clk_release: got %b expected 1", ok); end
        wait_end(d0, e0, ok);
        vectors++; if (cap !== 11'h7DA) begin miscompares++; $display("FAIL ed_wire: got %h expected 7da", cap); end
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL ed_done_count: got %0d expected 1", done_cnt - d0); end
        vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL ed_error_count: got %0d expected 0", err_cnt - e0); end
        vectors++; if (busy_at_done !== 1'b0) begin miscompares++; $display("FAIL ed_busy_at_done: got %b expected 0", busy_at_done); end
        vectors++; if (t_data_rise - t_clk_rise !== INH) begin miscompares++; $display("FAIL inhibit_len: got %0d expected %0d", t_data_rise - t_clk_rise, INH); end
        vectors++; if (t_clk_fall - t_data_rise !== 1) begin miscompares++; $display("FAIL req_len: got %0d expected 1", t_clk_fall - t_data_rise); end
    endtask

    task automatic test_parity;
        logic [7:0]  pd [3];
        logic [10:0] pe [3];
        logic [10:0] cap;
        logic ok;
        int d0, e0;
        pd = '{8'h00, 8'hFF, 8'h01};
        pe = '{11'h600, 11'h7FE, 11'h402};
        for (int i = 0; i < 3; i++) begin
            d0 = done_cnt; e0 = err_cnt;
            start_tx(pd[i]);
            dev_frame(12, 1'b1, cap, ok);
            wait_end(d0, e0, ok);
            vectors++; if (cap[9] !== pe[i][9]) begin miscompares++; $display("FAIL parity_%h: got %b expected %b", pd[i], cap[9], pe[i][9]); end
            vectors++; if (cap !== pe[i]) begin miscompares++; $display("FAIL wire_%h: got %h expected %h", pd[i], cap, pe[i]); end
            vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL done_%h: got %0d expected 1", pd[i], done_cnt - d0); end
        end
    endtask

    task automatic test_timeout;
        int d0, e0;
        logic ok;
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h55);
        wait_end(d0, e0, ok);
        vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL tmo_error_count: got %0d expected 1", err_cnt - e0); end
        vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL tmo_done_count: got %0d expected 0", done_cnt - d0); end
        vectors++; if (t_err - t_data_rise !== TMO) begin miscompares++; $display("FAIL tmo_time: got %0d expected %0d", t_err - t_data_rise, TMO); end
        vectors++; if (oe_at_err !== 2'b00) begin miscompares++; $display("FAIL tmo_oe: got %b expected 00", oe_at_err); end
        vectors++; if (bus.tx_busy !== 1'b0) begin miscompares++; $display("FAIL tmo_busy: got %b expected 0", bus.tx_busy); end
    endtask

    task automatic test_ack_high;
        int d0, e0, exp_d, exp_e;
        logic [10:0] cap;
        logic ok;
`ifdef PS2TX_ACK_CHECK_EN
        exp_d = 0; exp_e = 1;
`else
        exp_d = 1; exp_e = 0;
`endif
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hED);
        dev_frame(12, 1'b0, cap, ok);
        wait_end(d0, e0, ok);
        vectors++; if (cap !== 11'h7DA) begin miscompares++; $display("FAIL nack_wire: got %h expected 7da", cap); end
        vectors++; if (done_cnt - d0 !== exp_d) begin miscompares++; $display("FAIL nack_done: got %0d expected %0d", done_cnt - d0, exp_d); end
        vectors++; if (err_cnt - e0 !== exp_e) begin miscompares++; $display("FAIL nack_error: got %0d expected %0d", err_cnt - e0, exp_e); end
    endtask

    task automatic test_reset_midframe;
        logic [10:0] cap;
        logic ok;
        start_tx(8'h00);
        dev_frame(5, 1'b1, cap, ok);
        vectors++; if (ps2data_oe !== 1'b1) begin miscompares++; $display("FAIL mid_data_oe: got %b expected 1", ps2data_oe); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (ps2data_oe !== 1'b0) begin miscompares++; $display("FAIL async_data_oe: got %b expected 0", ps2data_oe); end
        vectors++; if (ps2clk_oe !== 1'b0) begin miscompares++; $display("FAIL async_clk_oe: got %b expected 0", ps2clk_oe); end
        vectors++; if (bus.tx_busy !== 1'b0) begin miscompares++; $display("FAIL async_busy: got %b expected 0", bus.tx_busy); end
        dev_clk = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int d0, e0;
        logic [10:0] cap;
        logic ok;
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hF4);
        repeat (2) @(negedge clk);
        bus.tx_data  = 8'h55;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        dev_frame(12, 1'b1, cap, ok);
        wait_end(d0, e0, ok);
        vectors++; if (cap !== 11'h5E8) begin miscompares++; $display("FAIL f4_wire: got %h expected 5e8", cap); end
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL f4_done: got %0d expected 1", done_cnt - d0); end
        vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL f4_error: got %0d expected 0", err_cnt - e0); end
        repeat (30) @(negedge clk);
        vectors++; if (bus.tx_busy !== 1'b0) begin miscompares++; $display("FAIL no_queue_busy: got %b expected 0", bus.tx_busy); end
        vectors++; if (ps2clk_oe !== 1'b0) begin miscompares++; $display("FAIL no_queue_clk_oe: got %b expected 0", ps2clk_oe); end
    endtask

    initial begin
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        test_reset();
        test_frame_ed();
        test_parity();
        test_timeout();
        test_ack_high();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
